// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
//   DEF_NUM_REGS / DEF_ADDR_W / DEF_DATA_W : default geometry of the walked file
//   state_t                                : dump sequencer states
package regfile_dump_reader_pkg;

    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_register32_r_en.sv
// Enabled holding register with asynchronous active-low reset.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset, clears o_q
//   i_en    : load enable
//   i_d     : data loaded when i_en is high
//   o_q     : held value
module register32_r_en #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on a start pulse, walks registers 0..NUM_REGS-1
// through the file's read port and streams each word out over valid/ready.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : dump request, only honoured when idle
//   rd_addr      : read address driven to the register file
//   rd_data      : combinational read data for rd_addr
//   out_data     : word captured in the READ cycle
//   out_addr     : register address of out_data
//   out_valid    : out_data/out_addr valid, held until out_ready
//   out_ready    : sink accept
//   busy         : dump in progress
//   done         : one-cycle pulse after the last word is accepted
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_capture;

    // Word is snapshotted from the file only in READ; held through any stall.
    assign w_capture = (r_state == S_READ);

    register32_r_en #(
        .WIDTH(DATA_W)
    ) u_out_data (
        .i_clk  (clk),
        .i_rst_n(reset_n),
        .i_en   (w_capture),
        .i_d    (rd_data),
        .o_q    (out_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    r_out_addr  <= r_rd_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_rd_addr == LAST_ADDR) begin
                            // done is registered so it is high exactly while in DONE
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            r_state   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_rd_addr <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_addr   = r_rd_addr;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [NR];

    int n_checks;
    int n_fail;

    assign rd_data = mem[rd_addr];

    regfile_dump_reader #(
        .NUM_REGS(NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < NR; i++) mem[i] = 32'h1111_0000 + i;
    endtask

    // Wait for the dump to finish; an expired bound is a failed check.
    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while ((busy || done) && cyc < 60) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (busy || done) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%0b done=%0b still set after %0d cycles, required idle", name, busy, done, cyc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({out_valid, busy, done, out_addr, rd_addr, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: v=%0b b=%0b d=%0b oa=%0d ra=%0d od=%h, required all 0",
                     out_valid, busy, done, out_addr, rd_addr, out_data);
        end
        reset_n = 1'b1;
        tick();
        // start and stall in HOLD on word 0
        start = 1'b1; tick(); start = 1'b0; tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1111_0000) begin
            n_fail++;
            $display("FAIL reset_prehold: v=%0b od=%h, required 1 11110000", out_valid, out_data);
        end
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, out_addr, rd_addr, out_data} !== '0 || dut.r_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_midhold: v=%0b b=%0b d=%0b oa=%0d ra=%0d od=%h st=%0d, required all 0 IDLE",
                     out_valid, busy, done, out_addr, rd_addr, out_data, dut.r_state);
        end
        tick();
        reset_n = 1'b1;
        tick();
        // restart begins again at register 0
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 3'd0 || out_data !== 32'h1111_0000) begin
            n_fail++;
            $display("FAIL reset_restart: v=%0b oa=%0d od=%h, required 1 0 11110000", out_valid, out_addr, out_data);
        end
        drain("reset");
    endtask

    task automatic test_full_dump();
        int cyc, words, dones, done_cyc, first_v;
        cyc = 0; words = 0; dones = 0; done_cyc = -1; first_v = -1;
        out_ready = 1'b1;
        start = 1'b1;
        // cyc counts clock edges after start was driven (start sampled at edge 1)
        while (done_cyc < 0 && cyc < 40) begin
            tick();
            cyc++;
            start = 1'b0;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                n_checks++;
                if (out_addr !== AW'(words) || out_data !== 32'h1111_0000 + words) begin
                    n_fail++;
                    $display("FAIL full_word%0d: oa=%0d od=%h, required %0d %h",
                             words, out_addr, out_data, words, 32'h1111_0000 + words);
                end
                words++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        n_checks++;
        if (first_v != 2) begin
            n_fail++;
            $display("FAIL full_latency: first valid at edge %0d, required 2", first_v);
        end
        // done occupies the 18th cycle counting the start cycle as the first
        n_checks++;
        if (done_cyc != 17 || words != 8) begin
            n_fail++;
            $display("FAIL full_done: done at edge %0d words=%0d, required 17 8", done_cyc, words);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL full_after: busy=%0b done=%0b ra=%0d, required 0 0 0", busy, done, rd_addr);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        while (!(out_valid && out_addr == 3'd3) && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 3'd3 || out_data !== 32'h1111_0003) begin
                n_fail++;
                $display("FAIL bp_stall%0d: v=%0b oa=%0d od=%h, required 1 3 11110003", i, out_valid, out_addr, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: v=%0b, required 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 3'd4 || out_data !== 32'h1111_0004) begin
            n_fail++;
            $display("FAIL bp_next: v=%0b oa=%0d od=%h, required 1 4 11110004", out_valid, out_addr, out_data);
        end
        drain("bp");
    endtask

    task automatic test_snapshot();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        while (!(out_valid && out_addr == 3'd3) && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        mem[3] = 32'hDEAD_BEEF;
        mem[6] = 32'hCAFE_0006;
        tick(); tick();
        n_checks++;
        if (out_data !== 32'h1111_0003) begin
            n_fail++;
            $display("FAIL snap_reg3: od=%h, required 11110003", out_data);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_addr == 3'd6) && cyc < 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 3'd6 || out_data !== 32'hCAFE_0006) begin
            n_fail++;
            $display("FAIL snap_reg6: v=%0b oa=%0d od=%h, required 1 6 cafe0006", out_valid, out_addr, out_data);
        end
        drain("snap");
        preload();
    endtask

    task automatic test_stray_start();
        int cyc, words, dones;
        bit hold_pulsed, done_pulsed;
        cyc = 0; words = 0; dones = 0; hold_pulsed = 0; done_pulsed = 0;
        out_ready = 1'b1;
        start = 1'b1;
        while (cyc < 30) begin
            tick();
            cyc++;
            start = 1'b0;
            if (out_valid) begin
                words++;
                if (out_addr == 3'd2 && !hold_pulsed) begin
                    start = 1'b1;
                    hold_pulsed = 1;
                end
            end
            if (done) begin
                dones++;
                if (!done_pulsed) begin
                    start = 1'b1;
                    done_pulsed = 1;
                end
            end
        end
        n_checks++;
        if (words != 8 || dones != 1) begin
            n_fail++;
            $display("FAIL stray_count: words=%0d dones=%0d, required 8 1", words, dones);
        end
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || dut.r_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL stray_idle: busy=%0b v=%0b st=%0d, required 0 0 IDLE", busy, out_valid, dut.r_state);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preload();
        test_reset();
        test_full_dump();
        test_backpressure();
        test_snapshot();
        test_stray_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
